commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Synthesizable retirement tracer for the pipelined RISC-V core. Replaces the bench-only shift-register printing logic.
- Shadows the PC and instruction of each op from ID through a parametrised number of pipeline stages, tracking bubbles and hazard stalls.
- At the trace stage it pushes a commit record {seq, pc, inst} into a FIFO drained by a valid/ready consumer (bench monitor or debug port).
- Detects end-of-program (all-zero instruction) and keeps cycle and retire counters.

Parameters:
- XLEN, 32, width of pc and instruction fields.
- STAGES, 5, pipeline stage count; shadow stages are 2..STAGES.
- TRACE_STAGE, 4, stage at which a record is emitted; legal range 2..STAGES. Out-of-range values are a compile-time error.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the counters and the sequence number.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  tracing enable; when low, all state holds
- pc_i  in  XLEN  PC of the instruction in ID (stage 2)
- inst_i  in  XLEN  instruction in ID
- nop_i  in  1  ID slot is a bubble (flush/NOP injection)
- stall_i  in  1  hazard stall: ID is held and a bubble enters stage 3
- rec_valid_o  out  1  FIFO head valid
- rec_ready_i  in  1  consumer accepts head
- rec_pc_o  out  XLEN  head PC
- rec_inst_o  out  XLEN  head instruction
- rec_seq_o  out  CNT_W  head retire sequence number (0-based)
- level_o  out  clog2(DEPTH)+1  FIFO occupancy
- halt_o  out  1  sticky; end-of-program record has been pushed
- overflow_o  out  1  sticky; a record was dropped because the FIFO was full
- cycle_cnt_o  out  CNT_W  enabled-cycle count
- retire_cnt_o  out  CNT_W  records pushed

Behaviour:
- Reset (rst_i=0, async):
  - All shadow valid bits are 0.
  - FIFO is empty and rec_valid_o=0.
  - level_o, halt_o, overflow_o, both counters and the sequence number are 0.
  - Reset mid-operation discards every in-flight op and every buffered record.
- All updates below occur only on rising edges with start_i=1. With start_i=0 all state holds, including the counters.
- Shadow pipeline, per enabled edge:
  - s2 loads {pc_i, inst_i, valid=~nop_i}.
  - s3 loads s2, with valid = s2.valid & ~stall_i.
  - For k>3, s[k] loads s[k-1].
  - When TRACE_STAGE=2, the stall gating does not affect emission; s2 is emitted directly.
- Emission: on an enabled edge where s[TRACE_STAGE].valid=1 and halt_o=0, a push is requested for record {retire_cnt, pc, inst}.
- Latency: ID inputs sampled at edge E produce rec_valid_o high after edge E+(TRACE_STAGE-1) when no stall occurs. Default: E+3.
- Push when not full, or when full with a simultaneous pop:
  - The record is written.
  - retire_cnt increments, wrapping modulo 2^CNT_W.
- Push when full with no pop:
  - The record is dropped and overflow_o is set.
  - retire_cnt still increments, so the sequence gap shows the loss.
- Pop occurs on any edge where rec_valid_o & rec_ready_i; it is independent of start_i.
  - The head outputs are a combinational read of the storage array at the read pointer.
  - rec_*_o must not change while rec_valid_o=1 and rec_ready_i=0.
- Push and pop on the same edge: level_o is unchanged. This is legal when full or when holding a single entry.
- Pop when empty: impossible, since rec_valid_o=0.
- Pointers wrap modulo DEPTH. Fullness is tracked with an extra pointer bit.
- Halt:
  - A pushed record whose inst is 0 sets halt_o on the same edge. The record itself is still pushed (or dropped if full).
  - After halt, no further pushes occur. The shadow pipeline keeps shifting. Draining continues.
- cycle_cnt increments on every enabled edge, including after halt, and wraps modulo 2^CNT_W.

Decomposition:
- Shared package (core-wide debug package):
  - commit_rec_t struct {seq, pc, inst}.
  - NOP_INST constant 32'h00000013.
  - HALT_INST constant 32'h0.
- One sub-module: trace_fifo, a generic synchronous valid/ready FIFO parametrised by width and DEPTH. It owns the pointers, level and full/empty flags.
- The top level holds the shadow stage array, emission/halt/overflow logic and the counters.

Test Plan:
- Straight-line flow: addi, add, sub at PC 0x10008, 0x1000C, 0x10010, no stalls, ready=1 → three records, seq 0/1/2, each 3 cycles after its ID cycle; retire_cnt_o=3.
- Hazard stall: stall_i=1 for one cycle with the load in ID and the same PC held → exactly one record for that PC; a one-cycle gap in rec_valid_o; no duplicate record.
- Bubbles: nop_i=1 for two cycles → no records for those slots; seq stays contiguous.
- Backpressure/overflow with DEPTH=4 and ready=0 over 6 retirements:
  - level_o saturates at 4 and overflow_o=1.
  - Enabling ready then drains seq 0..3.
  - The next record carries seq 6.
- Full with simultaneous push and pop → no overflow; level_o stays 4.
- Halt: inst 0x00000000 at PC 0x10020 reaches TRACE_STAGE → record pushed and halt_o=1; later valid ops produce no records; cycle_cnt_o keeps counting.
- Async reset asserted mid-drain with 3 entries → rec_valid_o=0, level_o=0, counters 0, immediately without waiting for a clock edge.
- start_i=0 for 5 cycles → no state change; tracing resumes exactly where it stopped.

Source files
------------

// File: rtl/commit_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// commit_trace_buffer_pkg : shared debug types and constants for commit tracing
// Revision: 1.0
// ============================================================================
package commit_trace_buffer_pkg;

  localparam int TRACE_XLEN  = 32;
  localparam int TRACE_CNT_W = 32;

  localparam logic [TRACE_XLEN-1:0] NOP_INST  = 32'h0000_0013;
  localparam logic [TRACE_XLEN-1:0] HALT_INST = 32'h0000_0000;

  // Field order matches the packed record carried through the FIFO
  typedef struct packed {
    logic [TRACE_CNT_W-1:0] seq;
    logic [TRACE_XLEN-1:0]  pc;
    logic [TRACE_XLEN-1:0]  inst;
  } commit_rec_t;

endpackage
`default_nettype wire

// File: rtl/commit_trace_buffer_fifo.sv
`default_nettype none
// ============================================================================
// trace_fifo : generic synchronous valid/ready FIFO with extra-bit pointers
// Revision: 1.0
// ============================================================================
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     ready,
  output logic                     full,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("trace_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop;
  logic             wr_en;

  assign head_valid = (wr_ptr != rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level      = wr_ptr - rd_ptr;
  assign pop        = head_valid & ready;
  // When full, the slot being written is the head that leaves on this same edge
  assign wr_en      = push & (~full | pop);
  assign head_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// commit_trace_buffer : shadows ID ops down the pipe and queues commit records
// Revision: 1.0
// ============================================================================
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STAGES      = 5,
  parameter int TRACE_STAGE = 4,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        inst_i,
  input  logic                   nop_i,
  input  logic                   stall_i,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output logic [XLEN-1:0]        rec_pc_o,
  output logic [XLEN-1:0]        rec_inst_o,
  output logic [CNT_W-1:0]       rec_seq_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   halt_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       cycle_cnt_o,
  output logic [CNT_W-1:0]       retire_cnt_o
);

  localparam int REC_W = CNT_W + 2 * XLEN;
  localparam int LAST  = TRACE_STAGE;

  if (TRACE_STAGE < 2 || TRACE_STAGE > STAGES) begin : g_bad_trace_stage
    $error("commit_trace_buffer: TRACE_STAGE must lie in 2..STAGES");
  end

  // Stages past the trace point never influence a record, so only 2..TRACE_STAGE exist
  logic [LAST:2]   s_valid;
  logic [XLEN-1:0] s_pc   [2:LAST];
  logic [XLEN-1:0] s_inst [2:LAST];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       s_valid[2] <= 1'b0;
    else if (start_i) s_valid[2] <= ~nop_i;
  end

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      s_pc[2]   <= pc_i;
      s_inst[2] <= inst_i;
    end
  end

  for (genvar k = 3; k <= LAST; k++) begin : g_stage
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       s_valid[k] <= 1'b0;
      else if (start_i) s_valid[k] <= (k == 3) ? (s_valid[k-1] & ~stall_i) : s_valid[k-1];
    end

    always_ff @(posedge clk_i) begin
      if (start_i) begin
        s_pc[k]   <= s_pc[k-1];
        s_inst[k] <= s_inst[k-1];
      end
    end
  end

  logic             emit;
  logic             is_halt;
  logic             fifo_full;
  logic             drop;
  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] head_rec;

  assign emit     = start_i & s_valid[LAST] & ~halt_o;
  assign is_halt  = (s_inst[LAST] == XLEN'(HALT_INST));
  assign drop     = emit & fifo_full & ~(rec_valid_o & rec_ready_i);
  assign push_rec = {retire_cnt_o, s_pc[LAST], s_inst[LAST]};

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .push       (emit),
    .push_data  (push_rec),
    .ready      (rec_ready_i),
    .full       (fifo_full),
    .head_valid (rec_valid_o),
    .head_data  (head_rec),
    .level      (level_o)
  );

  assign rec_seq_o  = head_rec[REC_W-1 -: CNT_W];
  assign rec_pc_o   = head_rec[2*XLEN-1 -: XLEN];
  assign rec_inst_o = head_rec[XLEN-1:0];

  // Sequence advances on dropped records too, leaving a visible gap
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_o  <= '0;
      retire_cnt_o <= '0;
      halt_o       <= 1'b0;
      overflow_o   <= 1'b0;
    end else if (start_i) begin
      cycle_cnt_o <= cycle_cnt_o + 1'b1;
      if (emit) retire_cnt_o <= retire_cnt_o + 1'b1;
      if (emit & is_halt) halt_o <= 1'b1;
      if (drop) overflow_o <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// tb_commit_trace_buffer : directed checks of the commit trace buffer (DEPTH=4)
// Revision: 1.0
// ============================================================================
module tb_commit_trace_buffer;
  import commit_trace_buffer_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int DEPTH = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [XLEN-1:0]   pc    = '0;
  logic [XLEN-1:0]   inst  = NOP_INST;
  logic              nop   = 1'b1;
  logic              stall = 1'b0;
  logic              ready = 1'b1;
  logic              rec_valid;
  logic [XLEN-1:0]   rec_pc;
  logic [XLEN-1:0]   rec_inst;
  logic [CNT_W-1:0]  rec_seq;
  logic [2:0]        level;
  logic              halt;
  logic              overflow;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  retire_cnt;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  commit_trace_buffer #(
    .XLEN(XLEN), .STAGES(5), .TRACE_STAGE(4), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .pc_i(pc), .inst_i(inst),
    .nop_i(nop), .stall_i(stall), .rec_valid_o(rec_valid), .rec_ready_i(ready),
    .rec_pc_o(rec_pc), .rec_inst_o(rec_inst), .rec_seq_o(rec_seq),
    .level_o(level), .halt_o(halt), .overflow_o(overflow),
    .cycle_cnt_o(cycle_cnt), .retire_cnt_o(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] i, input logic [31:0] s);
    commit_rec_t exp;
    chk({tag, "_valid"}, 128'(rec_valid), 128'(v));
    if (v) begin
      exp = '{seq: s, pc: p, inst: i};
      chk({tag, "_rec"}, 128'({rec_seq, rec_pc, rec_inst}), 128'(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (start && rst_n) ncyc++;
    #1;
  endtask

  task automatic issue(input logic [31:0] p, input logic [31:0] i);
    pc = p; inst = i; nop = 1'b0;
    tick();
  endtask

  task automatic bub();
    nop = 1'b1;
    tick();
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0513;
  localparam logic [31:0] ADD  = 32'h00B5_0533;
  localparam logic [31:0] SUB  = 32'h40B5_0533;
  localparam logic [31:0] LW   = 32'h0002_A303;
  localparam logic [31:0] OPA  = 32'h0010_0093;
  localparam logic [31:0] OPB  = 32'h0020_0113;

  initial begin
    #2;
    chk("rst_valid", 128'(rec_valid), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_flags", 128'({halt, overflow}), 128'(0));
    chk("rst_cnts", 128'({cycle_cnt, retire_cnt}), 128'(0));
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; start = 1'b1;

    // straight-line flow
    issue(32'h10008, ADDI);
    issue(32'h1000C, ADD);
    issue(32'h10010, SUB);
    chk("lat_not_yet", 128'(rec_valid), 128'(0));
    bub(); chk_head("flow0", 1, 32'h10008, ADDI, 0);
    bub(); chk_head("flow1", 1, 32'h1000C, ADD, 1);
    bub(); chk_head("flow2", 1, 32'h10010, SUB, 2);
    bub(); chk_head("flow_end", 0, 0, 0, 0);
    chk("flow_retire", 128'(retire_cnt), 128'(3));
    chk("flow_cycles", 128'(cycle_cnt), 128'(ncyc));

    // hazard stall: load held in ID for one extra cycle
    issue(32'h10014, LW);
    stall = 1'b1; issue(32'h10014, LW);
    stall = 1'b0; issue(32'h10018, ADD);
    bub(); chk_head("stall_gap", 0, 0, 0, 0);
    bub(); chk_head("stall_lw", 1, 32'h10014, LW, 3);
    bub(); chk_head("stall_add", 1, 32'h10018, ADD, 4);
    bub(); chk_head("stall_nodup", 0, 0, 0, 0);
    chk("stall_retire", 128'(retire_cnt), 128'(5));

    // bubbles
    issue(32'h1001C, OPA);
    bub(); bub();
    issue(32'h10030, OPB);
    chk_head("bub_a", 1, 32'h1001C, OPA, 5);
    bub(); chk_head("bub_gap1", 0, 0, 0, 0);
    bub(); chk_head("bub_gap2", 0, 0, 0, 0);
    bub(); chk_head("bub_b", 1, 32'h10030, OPB, 6);
    bub();

    // backpressure, full push+pop, overflow
    ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(32'h10100 + 32'(4 * i), OPA);
    chk("bp_level0", 128'(level), 128'(0));
    for (int i = 3; i < 7; i++) issue(32'h10100 + 32'(4 * i), OPA);
    chk("bp_level4", 128'(level), 128'(4));
    chk("bp_noovf", 128'(overflow), 128'(0));
    chk_head("bp_head7", 1, 32'h10100, OPA, 7);
    ready = 1'b1;
    bub();
    chk("fullpp_level", 128'(level), 128'(4));
    chk("fullpp_noovf", 128'(overflow), 128'(0));
    chk_head("fullpp_head", 1, 32'h10104, OPA, 8);
    ready = 1'b0;
    bub(); bub();
    chk("ovf_level", 128'(level), 128'(4));
    chk("ovf_flag", 128'(overflow), 128'(1));
    chk_head("ovf_hold", 1, 32'h10104, OPA, 8);
    chk("ovf_retire", 128'(retire_cnt), 128'(14));
    ready = 1'b1;
    issue(32'h10200, OPB);
    chk_head("drain9", 1, 32'h10108, OPA, 9);
    bub(); bub();
    chk_head("drain11", 1, 32'h10110, OPA, 11);
    bub();
    chk_head("after_gap", 1, 32'h10200, OPB, 14);
    chk("after_gap_level", 128'(level), 128'(1));
    bub(); chk_head("drain_empty", 0, 0, 0, 0);

    // start_i low: everything holds, in-flight op resumes
    issue(32'h10300, ADD);
    start = 1'b0; nop = 1'b0; pc = 32'hDEAD_BEEC; inst = SUB;
    repeat (5) tick();
    chk("pause_cycles", 128'(cycle_cnt), 128'(ncyc));
    chk("pause_retire", 128'(retire_cnt), 128'(15));
    chk_head("pause_none", 0, 0, 0, 0);
    start = 1'b1;
    bub(); bub();
    chk_head("resume_early", 0, 0, 0, 0);
    bub(); chk_head("resume_rec", 1, 32'h10300, ADD, 15);

    // halt
    issue(32'h10020, HALT_INST);
    issue(32'h10024, OPA);
    issue(32'h10028, OPB);
    bub(); chk_head("halt_rec", 1, 32'h10020, HALT_INST, 16);
    chk("halt_flag", 128'(halt), 128'(1));
    bub(); chk_head("halt_nomore", 0, 0, 0, 0);
    bub(); bub();
    chk_head("halt_nomore2", 0, 0, 0, 0);
    chk("halt_retire", 128'(retire_cnt), 128'(17));
    chk("halt_cycles", 128'(cycle_cnt), 128'(ncyc));

    // async reset clears sticky flags without a clock edge
    #2; rst_n = 1'b0; #1;
    chk("rst1_flags", 128'({halt, overflow}), 128'(0));
    chk("rst1_cnts", 128'({cycle_cnt, retire_cnt}), 128'(0));
    ncyc = 0; rst_n = 1'b1;

    // async reset mid-drain with three entries buffered
    ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(32'h10400 + 32'(4 * i), OPA);
    bub();
    chk("md_level3", 128'(level), 128'(3));
    chk_head("md_head0", 1, 32'h10400, OPA, 0);
    ready = 1'b1;
    bub();
    chk("md_level_pp", 128'(level), 128'(3));
    chk_head("md_head1", 1, 32'h10404, OPA, 1);
    #2; rst_n = 1'b0; #1;
    chk("rst2_valid", 128'(rec_valid), 128'(0));
    chk("rst2_level", 128'(level), 128'(0));
    chk("rst2_cnts", 128'({cycle_cnt, retire_cnt}), 128'(0));
    ncyc = 0; rst_n = 1'b1;
    repeat (4) bub();
    chk_head("rst2_discard", 0, 0, 0, 0);
    chk("rst2_retire", 128'(retire_cnt), 128'(0));
    chk("rst2_cycles", 128'(cycle_cnt), 128'(ncyc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
